// File: rtl/alu_writeback.sv
// alu_writeback: commit stage for the SPARCv8 integer ALU.
// Holds the architectural ICC and Y, drives the register-file write port,
// and raises precise traps for division by zero and tagged overflow.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   in_valid/in_ready                   result handshake (in_ready is combinational)
//   in_opcode, in_rd_addr, in_result    ALU opcode, destination, rd value
//   in_icc, in_y                        ALU NZVC and Y outputs
//   in_div_zero, in_tag_ovf             ALU exception flags
//   icc, y                              architectural state fed back to the ALU
//   rf_we, rf_waddr, rf_wdata           registered register-file write port
//   trap_valid, trap_tt, trap_ack       trap request and acknowledge
//   flush                               pipeline flush
//   retired                             count of committed results
module alu_writeback #(
    parameter logic [7:0] TT_DIV_ZERO = 8'h2A,
    parameter logic [7:0] TT_TAG_OVF  = 8'h0A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_result,
    input  logic [3:0]  in_icc,
    input  logic [31:0] in_y,
    input  logic        in_div_zero,
    input  logic        in_tag_ovf,
    output logic [3:0]  icc,
    output logic [31:0] y,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        trap_valid,
    output logic [7:0]  trap_tt,
    input  logic        trap_ack,
    input  logic        flush,
    output logic [31:0] retired
);
    typedef enum logic {RUN, TRAP} state_t;

    state_t state, state_next;
    logic   accept, cc_wr, y_wr, tag_trap, take_trap;

    assign in_ready  = (state == RUN) && !flush && rst_n;
    assign accept    = in_valid && in_ready;
    assign cc_wr     = (in_opcode[5:4] == 2'b01) || (in_opcode >= 6'h20 && in_opcode <= 6'h24);
    assign y_wr      = in_opcode inside {6'h0A, 6'h0B, 6'h1A, 6'h1B, 6'h24};
    assign tag_trap  = in_opcode inside {6'h22, 6'h23};
    assign take_trap = in_div_zero || (in_tag_ovf && tag_trap);

    always_comb begin
        state_next = state;
        if (state == RUN && accept && take_trap)
            state_next = TRAP;
        else if (state == TRAP && (trap_ack || flush))
            state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icc        <= 4'b0000;
            y          <= 32'h0;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'h0;
            trap_valid <= 1'b0;
            trap_tt    <= 8'h00;
            retired    <= 32'h0;
        end else begin
            rf_we <= 1'b0;
            if (state == TRAP && (trap_ack || flush))
                trap_valid <= 1'b0;
            if (accept && take_trap) begin
                trap_valid <= 1'b1;
                trap_tt    <= in_div_zero ? TT_DIV_ZERO : TT_TAG_OVF;
            end else if (accept) begin
                // %g0 writes still commit icc/y and count as retired
                if (cc_wr)
                    icc <= in_icc;
                if (y_wr)
                    y <= in_y;
                rf_we    <= (in_rd_addr != 5'd0);
                rf_waddr <= in_rd_addr;
                rf_wdata <= in_result;
                retired  <= retired + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: randomized and directed check of alu_writeback against a behavioural model.
module tb_alu_writeback;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_div_zero, in_tag_ovf;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rd_addr, rf_waddr;
    logic [31:0] in_result, in_y, y, rf_wdata, retired;
    logic [3:0]  in_icc, icc;
    logic        rf_we, trap_valid, trap_ack, flush;
    logic [7:0]  trap_tt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  m_icc;
    logic [31:0] m_y, m_wdata, m_ret;
    logic [4:0]  m_waddr;
    logic        m_we, m_trap;
    logic [7:0]  m_tt;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd_addr(in_rd_addr), .in_result(in_result),
        .in_icc(in_icc), .in_y(in_y), .in_div_zero(in_div_zero), .in_tag_ovf(in_tag_ovf),
        .icc(icc), .y(y), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .trap_valid(trap_valid), .trap_tt(trap_tt), .trap_ack(trap_ack),
        .flush(flush), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; in_valid = 1'b0; in_opcode = 6'h00; in_rd_addr = 5'd0;
        in_result = 32'h0; in_icc = 4'h0; in_y = 32'h0; in_div_zero = 1'b0;
        in_tag_ovf = 1'b0; trap_ack = 1'b0; flush = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] res,
                        input logic [3:0] ic, input logic [31:0] yv, input logic dz, input logic tov);
        idle();
        in_valid = 1'b1; in_opcode = op; in_rd_addr = rd; in_result = res;
        in_icc = ic; in_y = yv; in_div_zero = dz; in_tag_ovf = tov;
    endtask

    // One clock: checks in_ready, advances the model on the edge, checks registered outputs.
    task automatic tick();
        logic exp_ready, acc, trap;
        #1;
        exp_ready = rst_n && !m_trap && !flush;
        chk("in_ready", in_ready, exp_ready);
        acc = in_valid && exp_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_icc = 0; m_y = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
            m_trap = 0; m_tt = 0; m_ret = 0;
        end else begin
            m_we = 0;
            if (m_trap && (trap_ack || flush)) m_trap = 0;
            if (acc) begin
                trap = in_div_zero || (in_tag_ovf && (in_opcode == 6'h22 || in_opcode == 6'h23));
                if (trap) begin
                    m_trap = 1;
                    m_tt = in_div_zero ? 8'h2A : 8'h0A;
                end else begin
                    if (in_opcode[5:4] == 2'b01 || (in_opcode >= 6'h20 && in_opcode <= 6'h24)) m_icc = in_icc;
                    if (in_opcode inside {6'h0A, 6'h0B, 6'h1A, 6'h1B, 6'h24}) m_y = in_y;
                    m_we = in_rd_addr != 0;
                    m_waddr = in_rd_addr;
                    m_wdata = in_result;
                    m_ret = m_ret + 1;
                end
            end
        end
        #1;
        chk("icc", icc, m_icc);
        chk("y", y, m_y);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        chk("trap_valid", trap_valid, m_trap);
        if (m_trap) chk("trap_tt", trap_tt, m_tt);
        chk("retired", retired, m_ret);
    endtask

    initial begin
        logic [5:0] ops [12] = '{6'h00, 6'h10, 6'h1A, 6'h0A, 6'h0E, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h1B, 6'h30};
        m_icc = 0; m_y = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_trap = 0; m_tt = 0; m_ret = 0;
        idle();
        rst_n = 1'b0;
        tick(); tick();
        chk("reset_waddr", rf_waddr, 32'd0);
        chk("reset_wdata", rf_wdata, 32'd0);
        chk("reset_tt", trap_tt, 32'd0);

        send(6'h10, 5'd5, 32'h0, 4'b0100, 32'h0, 0, 0); tick();
        chk("addcc_we", rf_we, 32'd1);
        chk("addcc_waddr", rf_waddr, 32'd5);
        chk("addcc_icc", icc, 32'h4);
        chk("addcc_ret", retired, 32'd1);

        send(6'h1A, 5'd0, 32'hFFFFFFFE, 4'b1000, 32'h1, 0, 0); tick();
        chk("umulcc_y", y, 32'h1);
        chk("umulcc_we", rf_we, 32'd0);
        chk("umulcc_ret", retired, 32'd2);

        send(6'h10, 5'd1, 32'h7, 4'b0011, 32'h0, 0, 0); tick();
        send(6'h0E, 5'd3, 32'h0, 4'b1111, 32'h0, 1, 0); tick();
        for (int i = 0; i < 5; i++) begin
            send(6'h10, 5'd4, 32'h9, 4'b1111, 32'h0, 0, 0); tick();
            chk("udiv_tt", trap_tt, 32'h2A);
            chk("udiv_icc", icc, 32'h3);
        end
        idle(); trap_ack = 1'b1; tick();
        idle(); tick();
        chk("ack_ready", in_ready, 32'd1);

        send(6'h20, 5'd2, 32'h5, 4'b0010, 32'h0, 0, 1); tick();
        chk("tadd_icc", icc, 32'h2);
        send(6'h22, 5'd2, 32'h5, 4'b1010, 32'h0, 0, 1); tick();
        chk("taddtv_tt", trap_tt, 32'h0A);
        idle(); flush = 1'b1; tick();
        send(6'h23, 5'd2, 32'h5, 4'b1010, 32'h0, 1, 1); tick();
        chk("both_tt", trap_tt, 32'h2A);
        idle(); trap_ack = 1'b1; flush = 1'b1; tick();

        send(6'h10, 5'd6, 32'h1, 4'b0001, 32'h0, 0, 0); tick();
        chk("b2b_c", icc, 32'h1);
        send(6'h00, 5'd7, 32'h2, 4'b1000, 32'h0, 0, 0); tick();
        chk("b2b_add_icc", icc, 32'h1);
        chk("b2b_we", rf_we, 32'd1);

        send(6'h10, 5'd8, 32'h3, 4'b0000, 32'h0, 0, 0); flush = 1'b1; tick();
        send(6'h0E, 5'd3, 32'h0, 4'b0000, 32'h0, 1, 0); tick();
        send(6'h10, 5'd3, 32'h0, 4'b0000, 32'h0, 0, 0); rst_n = 1'b0; tick();
        chk("rst_trap_tt", trap_tt, 32'h0);
        idle(); tick();

        force dut.retired = 32'hFFFFFFFF;
        #1 release dut.retired;
        m_ret = 32'hFFFFFFFF;
        send(6'h00, 5'd9, 32'h1, 4'b0000, 32'h0, 0, 0); tick();
        chk("ret_wrap", retired, 32'h0);

        for (int i = 0; i < 400; i++) begin
            send(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 31)), $urandom,
                 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) in_opcode = 6'($urandom_range(0, 63));
            in_valid = $urandom_range(0, 3) != 0;
            trap_ack = $urandom_range(0, 5) == 0;
            flush = $urandom_range(0, 15) == 0;
            rst_n = $urandom_range(0, 49) != 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
